// File: rtl/fetch_decode_unit.sv
// MIPS front-end: PC register with sequential increment and a registered
// instruction-field splitter that lags the PC by one cycle.
module fetch_decode_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  input  logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] address
);

  // Field layout of a MIPS word; the overlapping views are plain slices.
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;

  instr_t      instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc_nxt;

  assign pc_plus4 = pc_q + PC_STEP;

  // Targets are forced to word alignment so pc can never go misaligned.
  always_comb begin
    pc_nxt = pc_plus4;
    if (pc_load) pc_nxt = {pc_target[31:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      pc_q    <= pc_nxt;
      instr_q <= instr_t'(instr);
    end
  end

  assign pc      = pc_q;
  assign opcode  = instr_q.opcode;
  assign rs      = instr_q.rs;
  assign rt      = instr_q.rt;
  assign rd      = instr_q.rd;
  assign shamt   = instr_q.shamt;
  assign funct   = instr_q.funct;
  assign imm16   = {instr_q.rd, instr_q.shamt, instr_q.funct};
  assign address = {instr_q.rs, instr_q.rt, instr_q.rd, instr_q.shamt, instr_q.funct};

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Self-checking bench for fetch_decode_unit: directed cases plus a randomized
// run against a cycle-level behavioural model of PC and decoded word.
module tb_fetch_decode_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, pc_load;
  logic [31:0] pc_target, instr;
  logic [31:0] pc, pc_plus4;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] address;

  int total = 0;
  int bad   = 0;

  // model state: PC and the instruction word last captured
  logic [31:0] pc_m;
  logic [31:0] word_m;

  fetch_decode_unit dut (
    .clk(clk), .reset(reset), .pc_load(pc_load), .pc_target(pc_target),
    .instr(instr), .pc(pc), .pc_plus4(pc_plus4), .opcode(opcode), .rs(rs),
    .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm16(imm16),
    .address(address)
  );

  always #5 clk = ~clk;

  logic [73:0] got_f;
  assign got_f = {opcode, rs, rt, rd, shamt, funct, imm16, address};

  function automatic logic [73:0] exp_fields(input logic [31:0] w);
    logic [5:0]  op, fn;
    logic [4:0]  s, t, d, sh;
    logic [15:0] im;
    logic [25:0] ad;
    op = 6'((w / 32'd67108864) % 32'd64);
    s  = 5'((w / 32'd2097152) % 32'd32);
    t  = 5'((w / 32'd65536) % 32'd32);
    d  = 5'((w / 32'd2048) % 32'd32);
    sh = 5'((w / 32'd64) % 32'd32);
    fn = 6'(w % 32'd64);
    im = 16'(w % 32'd65536);
    ad = 26'(w % 32'd67108864);
    return {op, s, t, d, sh, fn, im, ad};
  endfunction

  // one rising edge; model advances with the inputs present at that edge
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      pc_m   = RST_PC;
      word_m = 32'd0;
    end else begin
      pc_m   = pc_load ? (pc_target - (pc_target % 32'd4)) : pc_m + 32'd4;
      word_m = instr;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pc_load = 1'b1; pc_target = 32'h100; instr = $urandom;
    tick();
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL reset_pc_plus4 got=%h exp=%h", pc_plus4, 32'h4); end
    total++; if (got_f !== 74'd0) begin bad++; $display("FAIL reset_fields got=%h exp=0", got_f); end
  endtask

  task automatic test_sequential();
    reset = 1'b0; pc_load = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      instr = $urandom;
      tick();
      total++; if (pc !== 32'(4 * i)) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc, 32'(4 * i)); end
      total++; if (pc_plus4 !== pc_m + 32'd4) begin bad++; $display("FAIL seq_plus4[%0d] got=%h exp=%h", i, pc_plus4, pc_m + 32'd4); end
      total++; if (got_f !== exp_fields(word_m)) begin bad++; $display("FAIL seq_fields[%0d] got=%h exp=%h", i, got_f, exp_fields(word_m)); end
    end
  endtask

  task automatic test_load();
    pc_load = 1'b1; pc_target = 32'h0040_0003;
    tick();
    total++; if (pc !== 32'h0040_0000) begin bad++; $display("FAIL load_align got=%h exp=%h", pc, 32'h0040_0000); end
    pc_load = 1'b0;
    tick();
    total++; if (pc !== 32'h0040_0004) begin bad++; $display("FAIL load_then_seq got=%h exp=%h", pc, 32'h0040_0004); end
  endtask

  task automatic test_wrap();
    pc_load = 1'b1; pc_target = 32'hFFFF_FFFC;
    tick();
    total++; if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_load got=%h exp=%h", pc, 32'hFFFF_FFFC); end
    total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_plus4 got=%h exp=0", pc_plus4); end
    pc_load = 1'b0;
    tick();
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=0", pc); end
  endtask

  task automatic test_decode();
    instr = 32'h012A_4020;
    tick();
    total++;
    if (opcode !== 6'd0 || rs !== 5'd9 || rt !== 5'd10 || rd !== 5'd8 ||
        shamt !== 5'd0 || funct !== 6'h20 || imm16 !== 16'h4020 || address !== 26'h12A_4020) begin
      bad++;
      $display("FAIL decode_add got=%h exp=%h", got_f,
               {6'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h4020, 26'h12A_4020});
    end
  endtask

  task automatic test_mid_reset();
    instr = 32'h8D09_0004;
    tick();
    total++;
    if (opcode !== 6'h23 || rs !== 5'd8 || rt !== 5'd9 || imm16 !== 16'h0004) begin
      bad++; $display("FAIL decode_lw got op=%h rs=%0d rt=%0d imm=%h exp op=23 rs=8 rt=9 imm=0004", opcode, rs, rt, imm16);
    end
    reset = 1'b1; pc_load = 1'b1; pc_target = 32'h1234_5678; instr = $urandom;
    tick();
    total++; if (pc !== RST_PC) begin bad++; $display("FAIL midreset_pc got=%h exp=%h", pc, RST_PC); end
    total++; if (got_f !== 74'd0) begin bad++; $display("FAIL midreset_fields got=%h exp=0", got_f); end
    reset = 1'b0; pc_load = 1'b0;
    tick();
    total++; if (pc !== RST_PC + 32'd4) begin bad++; $display("FAIL resume_pc got=%h exp=%h", pc, RST_PC + 32'd4); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      reset     = ($urandom_range(15) == 0);
      pc_load   = ($urandom_range(3) == 0);
      pc_target = ($urandom_range(7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : $urandom;
      instr     = $urandom;
      tick();
      total++; if (pc !== pc_m) begin bad++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, pc, pc_m); end
      total++; if (pc_plus4 !== pc_m + 32'd4) begin bad++; $display("FAIL rnd_plus4[%0d] got=%h exp=%h", i, pc_plus4, pc_m + 32'd4); end
      total++; if (got_f !== exp_fields(word_m)) begin bad++; $display("FAIL rnd_fields[%0d] got=%h exp=%h", i, got_f, exp_fields(word_m)); end
    end
  endtask

  initial begin
    reset = 1'b1; pc_load = 1'b0; pc_target = '0; instr = '0;
    pc_m = RST_PC; word_m = '0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_load();
    test_wrap();
    test_decode();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
